// File: rtl/rob_nway_pkg.sv
// -----------------------------------------------------------------------------
// rob_nway_pkg
// Shared types for the N-way reorder buffer.
//   ROB_NWAY_STATE_t : controller state (RUN, RECOVER, HALTED)
//   ROB_NWAY_ENTRY_t : one buffer slot (status bits + retire payload)
//   popcount()       : ones count of a lane mask (up to 32 lanes)
// The entry payload fields are sized for the largest supported tag widths.
// The buffer zero-extends narrower tags on write and truncates them on read,
// so PR_W must not exceed ENTRY_PR_W and AR_W must not exceed ENTRY_AR_W.
// -----------------------------------------------------------------------------
package rob_nway_pkg;

    localparam int ENTRY_PR_W = 10;
    localparam int ENTRY_AR_W = 8;

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        HALTED
    } ROB_NWAY_STATE_t;

    typedef struct packed {
        logic                  valid;
        logic                  complete;
        logic                  halt;
        logic [ENTRY_PR_W-1:0] T_idx;
        logic [ENTRY_PR_W-1:0] Told_idx;
        logic [ENTRY_AR_W-1:0] dest_idx;
    } ROB_NWAY_ENTRY_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_nway_if.sv
// -----------------------------------------------------------------------------
// rob_nway_if
// Dispatch / complete / rollback / retire bundle of the reorder buffer.
//   master : the pipeline side (drives dispatch, completion, rollback)
//   slave  : the reorder buffer (drives ready, slot indices, retire lanes)
// Multi-lane fields are packed with lane k at bits [k*W +: W].
// -----------------------------------------------------------------------------
interface rob_nway_if #(
    parameter int NUM_ROB   = 32,
    parameter int NUM_SUPER = 4,
    parameter int PR_W      = 6,
    parameter int AR_W      = 5
);
    localparam int IDX_W = $clog2(NUM_ROB);

    logic [NUM_SUPER-1:0]       dispatch_valid;
    logic [NUM_SUPER*PR_W-1:0]  dispatch_T_idx;
    logic [NUM_SUPER*PR_W-1:0]  dispatch_Told_idx;
    logic [NUM_SUPER*AR_W-1:0]  dispatch_dest_idx;
    logic [NUM_SUPER-1:0]       dispatch_halt;
    logic                       dispatch_ready;
    logic [NUM_SUPER*IDX_W-1:0] dispatch_rob_idx;

    logic [NUM_SUPER-1:0]       complete_en;
    logic [NUM_SUPER*IDX_W-1:0] complete_rob_idx;

    logic                       rollback_en;
    logic [IDX_W-1:0]           rollback_idx;

    logic [NUM_SUPER-1:0]       retire_en;
    logic [NUM_SUPER*PR_W-1:0]  retire_T_idx;
    logic [NUM_SUPER*PR_W-1:0]  retire_Told_idx;
    logic [NUM_SUPER*AR_W-1:0]  retire_dest_idx;

    modport master (
        output dispatch_valid, dispatch_T_idx, dispatch_Told_idx,
               dispatch_dest_idx, dispatch_halt,
               complete_en, complete_rob_idx, rollback_en, rollback_idx,
        input  dispatch_ready, dispatch_rob_idx,
               retire_en, retire_T_idx, retire_Told_idx, retire_dest_idx
    );

    modport slave (
        input  dispatch_valid, dispatch_T_idx, dispatch_Told_idx,
               dispatch_dest_idx, dispatch_halt,
               complete_en, complete_rob_idx, rollback_en, rollback_idx,
        output dispatch_ready, dispatch_rob_idx,
               retire_en, retire_T_idx, retire_Told_idx, retire_dest_idx
    );

endinterface

// File: rtl/rob_retire_sel.sv
// -----------------------------------------------------------------------------
// rob_retire_sel
// Builds the contiguous retire mask from per-lane readiness, stopping after
// the first lane that retires a halt, and counts the retiring lanes.
//   enable   in  : retirement allowed at all this cycle
//   ready    in  : lane k slot is valid, complete and not beyond a rollback
//   halt     in  : lane k slot carries a halt
//   mask     out : prefix-AND retire mask
//   n_retire out : number of set bits in mask
// -----------------------------------------------------------------------------
module rob_retire_sel
    import rob_nway_pkg::*;
#(
    parameter int NUM_SUPER = 4,
    parameter int CNT_W     = 6
) (
    input  logic                 enable,
    input  logic [NUM_SUPER-1:0] ready,
    input  logic [NUM_SUPER-1:0] halt,
    output logic [NUM_SUPER-1:0] mask,
    output logic [CNT_W-1:0]     n_retire
);

    always_comb begin
        logic run;
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned (no latch); blocking '=' is correct here because 'run'
        // must carry each lane's result into the next iteration.
        mask = '0;
        run  = enable;
        for (int k = 0; k < NUM_SUPER; k++) begin
            run     = run & ready[k];
            mask[k] = run;
            run     = run & ~halt[k];   // a halt retires itself, nothing younger
        end
        n_retire = CNT_W'(popcount(32'(mask)));
    end

endmodule

// File: rtl/rob_nway.sv
// -----------------------------------------------------------------------------
// rob_nway
// NUM_SUPER-wide reorder buffer: in-order dispatch at tail, out-of-order
// completion, in-order retire from head, branch rollback and halt.
//   clock    in  : rising-edge clock
//   reset    in  : synchronous active-high reset (wins over en)
//   en       in  : global enable, all state holds when low
//   bus      slv : dispatch / complete / rollback / retire bundle
//   halt_out out : a halt entry retires this cycle
//   count    out : occupied entries
// retire_en / halt_out are combinational; the consumer qualifies them with en.
// -----------------------------------------------------------------------------
module rob_nway
    import rob_nway_pkg::*;
#(
    parameter int NUM_ROB   = 32,
    parameter int NUM_SUPER = 4,
    parameter int PR_W      = 6,
    parameter int AR_W      = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    rob_nway_if.slave                bus,
    output logic                     halt_out,
    output logic [$clog2(NUM_ROB):0] count
);

    localparam int IDX_W = $clog2(NUM_ROB);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] ROB_SIZE = CNT_W'(NUM_ROB);
    localparam logic [CNT_W-1:0] LANES    = CNT_W'(NUM_SUPER);

    ROB_NWAY_ENTRY_t      rob_q [NUM_ROB];
    logic [IDX_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q;
    ROB_NWAY_STATE_t      state_q;

    logic                 dispatch_fire;
    logic [CNT_W-1:0]     n_dispatch;
    logic                 rb_accept;
    logic [IDX_W-1:0]     rb_dist, rb_span;
    logic [NUM_ROB-1:0]   squash;
    logic [IDX_W-1:0]     retire_slot [NUM_SUPER];
    logic [NUM_SUPER-1:0] retire_ready, retire_halt, retire_mask;
    logic [CNT_W-1:0]     n_retire;

    assign count = count_q;

    // Dispatch: readiness uses the registered count only, no retire bypass.
    always_comb begin
        bus.dispatch_ready = (state_q == RUN) && ((ROB_SIZE - count_q) >= LANES)
                             && !bus.rollback_en;
        dispatch_fire = en && bus.dispatch_ready;
        n_dispatch    = dispatch_fire ? CNT_W'(popcount(32'(bus.dispatch_valid))) : '0;
        for (int k = 0; k < NUM_SUPER; k++) begin
            bus.dispatch_rob_idx[k*IDX_W +: IDX_W] = tail_q + IDX_W'(k);
        end
    end

    // Rollback keeps rollback_idx and squashes the rb_span entries after it.
    // Offsets are taken relative to rollback_idx+1 so wrap needs no special case.
    always_comb begin
        rb_accept = en && bus.rollback_en && (state_q != HALTED)
                    && rob_q[bus.rollback_idx].valid;
        rb_dist   = bus.rollback_idx - head_q;
        rb_span   = tail_q - bus.rollback_idx - IDX_W'(1);
        for (int i = 0; i < NUM_ROB; i++) begin
            squash[i] = (IDX_W'(i) - bus.rollback_idx - IDX_W'(1)) < rb_span;
        end
    end

    // Retire candidates: during an accepted rollback only slots up to and
    // including the branch may retire, so squashed work never escapes.
    always_comb begin
        for (int k = 0; k < NUM_SUPER; k++) begin
            retire_slot[k]  = head_q + IDX_W'(k);
            retire_ready[k] = rob_q[retire_slot[k]].valid && rob_q[retire_slot[k]].complete
                              && (!rb_accept || (IDX_W'(k) <= rb_dist));
            retire_halt[k]  = rob_q[retire_slot[k]].halt;
            bus.retire_T_idx[k*PR_W +: PR_W]    = PR_W'(rob_q[retire_slot[k]].T_idx);
            bus.retire_Told_idx[k*PR_W +: PR_W] = PR_W'(rob_q[retire_slot[k]].Told_idx);
            bus.retire_dest_idx[k*AR_W +: AR_W] = AR_W'(rob_q[retire_slot[k]].dest_idx);
        end
    end

    rob_retire_sel #(
        .NUM_SUPER (NUM_SUPER),
        .CNT_W     (CNT_W)
    ) u_retire_sel (
        .enable   (state_q != HALTED),
        .ready    (retire_ready),
        .halt     (retire_halt),
        .mask     (retire_mask),
        .n_retire (n_retire)
    );

    assign bus.retire_en = retire_mask;
    assign halt_out      = |(retire_mask & retire_halt);

    // NOTE: sequential state uses non-blocking '<=' only, so every read in this
    // block sees the pre-edge value and later writes to a slot override earlier
    // ones (completion < retire clear < squash < dispatch).
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= RUN;
            // NOTE: only the status bits are reset; payload fields are always
            // rewritten on dispatch before anything can read them.
            for (int i = 0; i < NUM_ROB; i++) begin
                rob_q[i].valid    <= 1'b0;
                rob_q[i].complete <= 1'b0;
                rob_q[i].halt     <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < NUM_SUPER; k++) begin
                if (bus.complete_en[k] && rob_q[bus.complete_rob_idx[k*IDX_W +: IDX_W]].valid)
                    rob_q[bus.complete_rob_idx[k*IDX_W +: IDX_W]].complete <= 1'b1;
            end
            for (int k = 0; k < NUM_SUPER; k++) begin
                if (retire_mask[k]) begin
                    rob_q[retire_slot[k]].valid    <= 1'b0;
                    rob_q[retire_slot[k]].complete <= 1'b0;
                end
            end
            if (rb_accept) begin
                for (int i = 0; i < NUM_ROB; i++) begin
                    if (squash[i]) begin
                        rob_q[i].valid    <= 1'b0;
                        rob_q[i].complete <= 1'b0;
                    end
                end
            end
            if (dispatch_fire) begin
                for (int k = 0; k < NUM_SUPER; k++) begin
                    if (bus.dispatch_valid[k]) begin
                        rob_q[tail_q + IDX_W'(k)] <= '{
                            valid:    1'b1,
                            complete: 1'b0,
                            halt:     bus.dispatch_halt[k],
                            T_idx:    ENTRY_PR_W'(bus.dispatch_T_idx[k*PR_W +: PR_W]),
                            Told_idx: ENTRY_PR_W'(bus.dispatch_Told_idx[k*PR_W +: PR_W]),
                            dest_idx: ENTRY_AR_W'(bus.dispatch_dest_idx[k*AR_W +: AR_W])
                        };
                    end
                end
            end

            head_q <= head_q + IDX_W'(n_retire);
            if (rb_accept) begin
                tail_q  <= bus.rollback_idx + IDX_W'(1);
                count_q <= CNT_W'(rb_dist) + CNT_W'(1) - n_retire;
            end else begin
                tail_q  <= tail_q + IDX_W'(n_dispatch);
                count_q <= count_q + n_dispatch - n_retire;
            end

            if (halt_out) begin
                state_q <= HALTED;
            end else begin
                case (state_q)
                    RUN:     state_q <= rb_accept ? RECOVER : RUN;
                    RECOVER: state_q <= rb_accept ? RECOVER : RUN;
                    default: state_q <= HALTED;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// -----------------------------------------------------------------------------
// tb_rob_nway
// Directed checks of rob_nway with 32 entries and 4 lanes: reset state,
// dispatch/complete/retire, fill and wrap, rollback, halt.
// -----------------------------------------------------------------------------
module tb_rob_nway;

    localparam int NUM_ROB   = 32;
    localparam int NUM_SUPER = 4;
    localparam int PR_W      = 6;
    localparam int AR_W      = 5;
    localparam int IDX_W     = 5;

    logic             clock = 1'b0;
    logic             reset;
    logic             en;
    logic             halt_out;
    logic [IDX_W:0]   count;

    int n_checks = 0;
    int n_fail   = 0;

    rob_nway_if #(.NUM_ROB(NUM_ROB), .NUM_SUPER(NUM_SUPER), .PR_W(PR_W), .AR_W(AR_W)) bus ();

    rob_nway #(.NUM_ROB(NUM_ROB), .NUM_SUPER(NUM_SUPER), .PR_W(PR_W), .AR_W(AR_W)) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .bus      (bus),
        .halt_out (halt_out),
        .count    (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [19:0] idx_vec(input int t);
        logic [19:0] v;
        for (int k = 0; k < 4; k++) v[k*5 +: 5] = 5'((t + k) % 32);
        return v;
    endfunction

    function automatic logic [23:0] pack6(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    function automatic logic [19:0] pack5(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic idle();
        bus.dispatch_valid    = '0;
        bus.dispatch_T_idx    = '0;
        bus.dispatch_Told_idx = '0;
        bus.dispatch_dest_idx = '0;
        bus.dispatch_halt     = '0;
        bus.complete_en       = '0;
        bus.complete_rob_idx  = '0;
        bus.rollback_en       = 1'b0;
        bus.rollback_idx      = '0;
    endtask

    // Lane k gets T = base+k, Told = base+k+32, dest = k+1.
    task automatic drive_dispatch(input logic [3:0] mask, input logic [3:0] hmask, input int base);
        bus.dispatch_valid = mask;
        bus.dispatch_halt  = hmask;
        for (int k = 0; k < 4; k++) begin
            bus.dispatch_T_idx[k*PR_W +: PR_W]    = PR_W'(base + k);
            bus.dispatch_Told_idx[k*PR_W +: PR_W] = PR_W'(base + k + 32);
            bus.dispatch_dest_idx[k*AR_W +: AR_W] = AR_W'(k + 1);
        end
    endtask

    task automatic drive_complete(input logic [3:0] mask, input int i0, input int i1,
                                  input int i2, input int i3);
        bus.complete_en      = mask;
        bus.complete_rob_idx = pack5(i0, i1, i2, i3);
    endtask

    task automatic do_reset(input logic en_val);
        idle();
        en    = en_val;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        en    = 1'b1;
    endtask

    initial begin
        en    = 1'b1;
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        settle();
        check("rst_count", count, 0);
        check("rst_retire_en", bus.retire_en, 0);
        check("rst_halt_out", halt_out, 0);
        check("rst_ready", bus.dispatch_ready, 1);

        // Four-lane dispatch from an empty buffer.
        drive_dispatch(4'hF, 4'h0, 10);
        settle();
        check("disp_idx_first", bus.dispatch_rob_idx, idx_vec(0));
        tick();
        idle();
        settle();
        check("disp_count4", count, 4);
        check("disp_retire_none", bus.retire_en, 0);
        check("disp_idx_after", bus.dispatch_rob_idx, idx_vec(4));

        // Complete 1,2 then 0: three lanes retire together.
        drive_complete(4'b0011, 1, 2, 0, 0);
        tick();
        idle();
        settle();
        check("retire_blocked_head", bus.retire_en, 0);
        drive_complete(4'b0001, 0, 0, 0, 0);
        tick();
        idle();
        settle();
        check("retire_mask_0111", bus.retire_en, 4'b0111);
        check("retire_T", bus.retire_T_idx, pack6(10, 11, 12, 13));
        check("retire_Told", bus.retire_Told_idx, pack6(42, 43, 44, 45));
        check("retire_dest", bus.retire_dest_idx, pack5(1, 2, 3, 4));
        check("retire_no_halt", halt_out, 0);
        tick();
        settle();
        check("retire_count1", count, 1);
        check("retire_idle", bus.retire_en, 0);
        drive_complete(4'b0001, 3, 0, 0, 0);
        tick();
        idle();
        settle();
        check("retire_head3", bus.retire_en, 4'b0001);
        check("retire_head3_T", bus.retire_T_idx[5:0], 13);
        tick();
        settle();
        check("drain_count0", count, 0);

        // Fill to full starting at tail 4; tail wraps 31->0 on the 7th group.
        for (int n = 0; n < 8; n++) begin
            drive_dispatch(4'hF, 4'h0, n);
            settle();
            check("fill_ready", bus.dispatch_ready, 1);
            check("fill_idx", bus.dispatch_rob_idx, idx_vec(4 + 4 * n));
            tick();
        end
        idle();
        settle();
        check("full_count", count, 32);
        check("full_ready", bus.dispatch_ready, 0);
        check("full_idx", bus.dispatch_rob_idx, idx_vec(4));
        drive_complete(4'hF, 4, 5, 6, 7);
        drive_dispatch(4'hF, 4'h0, 40);
        settle();
        check("full_ready_hold", bus.dispatch_ready, 0);
        tick();
        idle();
        drive_dispatch(4'hF, 4'h0, 40);
        settle();
        check("full_retire4", bus.retire_en, 4'hF);
        check("full_ready_no_bypass", bus.dispatch_ready, 0);
        check("full_no_dispatch", count, 32);
        tick();
        idle();
        settle();
        check("after_retire_count", count, 28);
        check("after_retire_ready", bus.dispatch_ready, 1);

        // Reset mid-operation with en low discards all entries.
        do_reset(1'b0);
        settle();
        check("rst2_count", count, 0);
        check("rst2_ready", bus.dispatch_ready, 1);
        check("rst2_idx", bus.dispatch_rob_idx, idx_vec(0));
        drive_complete(4'hF, 0, 1, 2, 3);
        tick();
        idle();
        settle();
        check("rst2_entries_invalid", bus.retire_en, 0);

        // Ten entries, then rollback to index 3.
        drive_dispatch(4'hF, 4'h0, 0);
        tick();
        drive_dispatch(4'hF, 4'h0, 4);
        tick();
        drive_dispatch(4'b0011, 4'h0, 8);
        tick();
        idle();
        settle();
        check("rb_count10", count, 10);
        check("rb_idx10", bus.dispatch_rob_idx, idx_vec(10));
        en = 1'b0;
        drive_dispatch(4'hF, 4'h0, 20);
        tick();
        idle();
        en = 1'b1;
        settle();
        check("en_low_holds", count, 10);
        bus.rollback_en  = 1'b1;
        bus.rollback_idx = 5'd3;
        drive_dispatch(4'hF, 4'h0, 20);
        drive_complete(4'b0001, 5, 0, 0, 0);
        settle();
        check("rb_ready_low", bus.dispatch_ready, 0);
        tick();
        idle();
        settle();
        check("rb_count4", count, 4);
        check("rb_tail4", bus.dispatch_rob_idx, idx_vec(4));
        check("rb_recover_ready", bus.dispatch_ready, 0);
        tick();
        settle();
        check("rb_run_ready", bus.dispatch_ready, 1);
        check("rb_count_stable", count, 4);
        drive_complete(4'hF, 0, 1, 2, 3);
        tick();
        idle();
        settle();
        check("rb_keep_retire", bus.retire_en, 4'hF);
        check("rb_keep_T", bus.retire_T_idx, pack6(0, 1, 2, 3));
        tick();
        settle();
        check("rb_drained", count, 0);
        drive_complete(4'hF, 4, 5, 6, 7);
        tick();
        idle();
        settle();
        check("rb_squashed_invalid", bus.retire_en, 0);
        bus.rollback_en  = 1'b1;
        bus.rollback_idx = 5'd20;
        tick();
        idle();
        settle();
        check("rb_invalid_count", count, 0);
        check("rb_invalid_ready", bus.dispatch_ready, 1);
        check("rb_invalid_tail", bus.dispatch_rob_idx, idx_vec(4));

        // Halt on lane 2: retire stops after it and the buffer freezes.
        do_reset(1'b1);
        drive_dispatch(4'hF, 4'b0100, 16);
        tick();
        idle();
        drive_complete(4'hF, 0, 1, 2, 3);
        tick();
        idle();
        settle();
        check("halt_retire_mask", bus.retire_en, 4'b0111);
        check("halt_out_pulse", halt_out, 1);
        tick();
        settle();
        check("halted_retire", bus.retire_en, 0);
        check("halted_halt_out", halt_out, 0);
        check("halted_ready", bus.dispatch_ready, 0);
        check("halted_count", count, 1);
        drive_dispatch(4'hF, 4'h0, 30);
        drive_complete(4'b0001, 3, 0, 0, 0);
        tick();
        idle();
        settle();
        check("halted_no_dispatch", count, 1);
        check("halted_still_no_retire", bus.retire_en, 0);
        do_reset(1'b1);
        settle();
        check("post_halt_ready", bus.dispatch_ready, 1);
        check("post_halt_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
